// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests and sequences multi-cycle EX ops.
// Define STALL_PERF_CNT_EN to build the stall_cycles performance counter.
module pipe_stall_ctrl #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                mc_abort,
  output logic [5:0]          stall,
  output logic                mc_busy,
  output logic                mc_done,
  output logic [31:0]         stall_cycles
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MC_RUN  = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [MC_CNT_W-1:0] cnt, cnt_nxt;
  logic [MC_CNT_W-1:0] n_eff;
  logic                start_ok;
  logic                ex_hold;

  assign n_eff    = (mc_cycles == '0) ? MC_CNT_W'(1) : mc_cycles;
  // abort beats a same-cycle start; starts are ignored while an op is running
  assign start_ok = mc_start & ~mc_abort & (state != MC_RUN);
  assign ex_hold  = stallreq_ex | start_ok | (state == MC_RUN);

  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = cnt;
    if (mc_abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == MC_RUN) begin
      cnt_nxt   = cnt - MC_CNT_W'(1);
      state_nxt = (cnt == MC_CNT_W'(1)) ? MC_DONE : MC_RUN;
    end else if (start_ok) begin
      if (n_eff > MC_CNT_W'(1)) begin
        state_nxt = MC_RUN;
        cnt_nxt   = n_eff - MC_CNT_W'(1);
      end else begin
        state_nxt = MC_DONE;
        cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (ex_hold)
      stall = 6'b001111;
    else if (stallreq_id)
      stall = 6'b000111;
  end

  assign mc_busy = (state == MC_RUN);
  assign mc_done = (state == MC_DONE);

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_cnt <= '0;
    else if (stall[0] && (perf_cnt != '1))
      perf_cnt <= perf_cnt + 32'd1;
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed table-driven bench for pipe_stall_ctrl plus hand-written reset/perf sequences.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, mc_start, mc_abort;
  logic [5:0]  mc_cycles;
  logic [5:0]  stall;
  logic        mc_busy, mc_done;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_stall_ctrl #(.MC_CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mc_start(mc_start), .mc_cycles(mc_cycles), .mc_abort(mc_abort),
    .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id, ex, start, abort;
    logic [5:0] cyc;
    logic [5:0] e_stall;
    logic       e_busy, e_done;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic id, ex, start, input logic [5:0] cyc, input logic abort,
                     input logic [5:0] e_stall, input logic e_busy, e_done);
    vec_t v;
    v.id = id; v.ex = ex; v.start = start; v.cyc = cyc; v.abort = abort;
    v.e_stall = e_stall; v.e_busy = e_busy; v.e_done = e_done;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, ex, start, input logic [5:0] cyc, input logic abort);
    stallreq_id = id; stallreq_ex = ex; mc_start = start; mc_cycles = cyc; mc_abort = abort;
  endtask

  task automatic check_outs(input string tag, input logic [5:0] s, input logic b, d);
    check({tag, ".stall"}, {26'd0, stall}, {26'd0, s});
    check({tag, ".busy"},  {31'd0, mc_busy}, {31'd0, b});
    check({tag, ".done"},  {31'd0, mc_done}, {31'd0, d});
  endtask

  localparam logic [5:0] S_EX = 6'b001111;
  localparam logic [5:0] S_ID = 6'b000111;
  localparam logic [5:0] S_0  = 6'b000000;

  int unsigned exp_perf;

  initial begin
    // id ex st cyc ab   stall busy done
    add(0,0,0,6'd0,0, S_0 ,0,0);  // 0 idle
    add(1,0,0,6'd0,0, S_ID,0,0);  // 1 id hazard
    add(0,0,0,6'd0,0, S_0 ,0,0);
    add(0,1,0,6'd0,0, S_EX,0,0);  // 3 ex single-cycle hold
    add(0,0,1,6'd4,0, S_EX,0,0);  // 4 start N=4
    add(0,0,0,6'd0,0, S_EX,1,0);
    add(1,0,0,6'd0,0, S_EX,1,0);  // id masked in RUN
    add(0,0,0,6'd0,0, S_EX,1,0);
    add(0,0,0,6'd0,0, S_0 ,0,1);  // 8 done at T+4
    add(0,0,0,6'd0,0, S_0 ,0,0);
    add(0,0,1,6'd0,0, S_EX,0,0);  // 10 N=0 treated as 1
    add(0,0,0,6'd0,0, S_0 ,0,1);
    add(0,0,1,6'd1,0, S_EX,0,0);  // 12 N=1
    add(0,0,0,6'd0,0, S_0 ,0,1);
    add(0,0,1,6'd8,0, S_EX,0,0);  // 14 N=8 then abort at T+3
    add(0,0,0,6'd0,0, S_EX,1,0);
    add(0,0,0,6'd0,0, S_EX,1,0);
    add(0,0,0,6'd0,1, S_EX,1,0);
    add(0,0,0,6'd0,0, S_0 ,0,0);
    add(0,0,0,6'd0,0, S_0 ,0,0);
    add(1,0,1,6'd3,0, S_EX,0,0);  // 20 N=3 with id held
    add(1,0,0,6'd0,0, S_EX,1,0);
    add(1,0,0,6'd0,0, S_EX,1,0);
    add(1,0,1,6'd2,0, S_EX,0,1);  // 23 back-to-back start in DONE
    add(1,0,0,6'd0,0, S_EX,1,0);
    add(1,0,0,6'd0,0, S_ID,0,1);
    add(1,0,0,6'd0,0, S_ID,0,0);
    add(0,0,1,6'd5,1, S_0 ,0,0);  // 27 abort suppresses start in IDLE
    add(0,0,0,6'd0,0, S_0 ,0,0);
    add(0,0,1,6'd3,0, S_EX,0,0);  // 29 N=3
    add(0,0,1,6'd9,0, S_EX,1,0);  // start ignored in RUN
    add(0,0,0,6'd0,0, S_EX,1,0);
    add(0,0,0,6'd0,0, S_0 ,0,1);
    add(0,0,0,6'd0,0, S_0 ,0,0);
    add(0,0,1,6'd1,0, S_EX,0,0);  // 34 N=1
    add(0,0,1,6'd3,1, S_0 ,0,1);  // abort in DONE beats start
    add(0,0,0,6'd0,0, S_0 ,0,0);

    drive(0,0,0,6'd0,0);
    rst = 1'b1;
    #2;
    check_outs("reset", S_0, 0, 0);
    check("reset.perf", stall_cycles, 32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    exp_perf = 0;
    foreach (vq[i]) begin
      drive(vq[i].id, vq[i].ex, vq[i].start, vq[i].cyc, vq[i].abort);
      #2;
      check_outs($sformatf("vec%0d", i), vq[i].e_stall, vq[i].e_busy, vq[i].e_done);
      if (vq[i].e_stall[0]) exp_perf++;
      @(posedge clk); #1;
    end
    drive(0,0,0,6'd0,0);
    #1;
`ifdef STALL_PERF_CNT_EN
    check("table.perf", stall_cycles, exp_perf);
`else
    check("table.perf", stall_cycles, 32'd0);
`endif

    // perf count after a 5-cycle op from a clean reset
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    drive(0,0,1,6'd5,0);
    #2 check_outs("op5.c0", S_EX, 0, 0);
    @(posedge clk); #1;
    drive(0,0,0,6'd0,0);
    for (int c = 1; c < 5; c++) begin
      #2 check_outs($sformatf("op5.c%0d", c), S_EX, 1, 0);
      @(posedge clk); #1;
    end
    #2 check_outs("op5.c5", S_0, 0, 1);
`ifdef STALL_PERF_CNT_EN
    check("op5.perf", stall_cycles, 32'd5);
`else
    check("op5.perf", stall_cycles, 32'd0);
`endif
    @(posedge clk); #1;

    // asynchronous reset in the middle of MC_RUN
    drive(0,0,1,6'd8,0);
    @(posedge clk); #1;
    drive(0,0,0,6'd0,0);
    @(posedge clk); #1;
    #1 check_outs("pre_rst", S_EX, 1, 0);
    rst = 1'b1;
    #1;
    check_outs("async_rst", S_0, 0, 0);
    check("async_rst.perf", stall_cycles, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check_outs($sformatf("post_rst%0d", c), S_0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
